// File: rtl/spi_frame_pkg.sv
// Shared constants for the SPI frame bridge: opcodes, status bit positions,
// reply filler and frame FSM encoding.
package spi_frame_pkg;

    localparam logic [7:0] OP_NOP        = 8'h00;
    localparam logic [7:0] OP_READ_DATA  = 8'h02;
    localparam logic [7:0] OP_WRITE_CMD  = 8'h03;
    localparam logic [7:0] OP_WRITE_DATA = 8'h04;
    localparam logic [7:0] OP_CLEAR      = 8'h05;

    // Sent on MISO whenever there is nothing meaningful to return.
    localparam logic [7:0] FILLER = 8'h42;

    localparam int ST_MARKER = 6;
    localparam int ST_LINK   = 5;
    localparam int ST_DROP   = 2;
    localparam int ST_FULL   = 1;
    localparam int ST_NEMPTY = 0;

    typedef enum logic [2:0] {
        S_IDLE,
        S_OPCODE,
        S_PAYLOAD,
        S_EXEC,
        S_TRAIL
    } frame_state_t;

    function automatic logic [7:0] status_byte(input logic link, input logic drop,
                                               input logic full, input logic nempty);
        logic [7:0] s;
        s            = '0;
        s[ST_MARKER] = 1'b1;
        s[ST_LINK]   = link;
        s[ST_DROP]   = drop;
        s[ST_FULL]   = full;
        s[ST_NEMPTY] = nempty;
        return s;
    endfunction

endpackage

// File: rtl/spi_frame_bridge_if.sv
// Pin and core-side bundle of the SPI frame bridge. The bridge is the slave.
interface spi_frame_bridge_if #(parameter int W = 32);
    logic         spi_sck;
    logic         spi_ss;
    logic         spi_mosi;
    logic         spi_miso;
    logic [7:0]   spi_cmd;
    logic         spi_cmd_valid;
    logic [W-1:0] spi_data_out;
    logic         spi_data_out_valid;
    logic [W-1:0] spi_data_in;
    logic         spi_data_in_valid;
    logic         spi_data_in_free;
    logic         link_up;
    logic         frame_err;

    modport slave (
        input  spi_sck, spi_ss, spi_mosi, spi_data_in, spi_data_in_valid,
        output spi_miso, spi_cmd, spi_cmd_valid, spi_data_out, spi_data_out_valid,
               spi_data_in_free, link_up, frame_err
    );

    modport master (
        output spi_sck, spi_ss, spi_mosi, spi_data_in, spi_data_in_valid,
        input  spi_miso, spi_cmd, spi_cmd_valid, spi_data_out, spi_data_out_valid,
               spi_data_in_free, link_up, frame_err
    );
endinterface

// File: rtl/spi_frame_bridge_word_fifo.sv
// Result FIFO: W x DEPTH, peek at head, pointers carry an extra wrap bit so
// full and empty are told apart without a separate counter.
module word_fifo #(
    parameter int W     = 32,
    parameter int DEPTH = 4
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         push,
    input  logic [W-1:0] push_data,
    input  logic         pop,
    input  logic         flush,
    output logic [W-1:0] head,
    output logic         full,
    output logic         empty
);
    localparam int AW = $clog2(DEPTH);

    logic [W-1:0] mem [DEPTH];
    logic [AW:0]  wr_ptr, rd_ptr;
    logic         do_push, do_pop;

    assign do_push = push && !full;
    assign do_pop  = pop && !empty;
    assign empty   = (wr_ptr == rd_ptr);
    assign full    = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
    assign head    = mem[rd_ptr[AW-1:0]];

    // Pointer update; flush beats a simultaneous push or pop.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
        end else if (flush) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + (AW+1)'(1);
            if (do_pop)  rd_ptr <= rd_ptr + (AW+1)'(1);
        end
    end

    // Storage write; contents need no reset since empty guards every read.
    always_ff @(posedge clk) begin
        if (do_push && !flush) mem[wr_ptr[AW-1:0]] <= push_data;
    end
endmodule

// File: rtl/spi_frame_bridge.sv
// Fabric SPI slave (mode 0) framing opcode + DATA_BYTES payload into command
// and data words for the core, returning status and FIFO'd result words.
module spi_frame_bridge import spi_frame_pkg::*; #(
    parameter int         DATA_BYTES = 4,
    parameter int         TX_DEPTH   = 4,
    parameter bit         LSB_FIRST  = 1'b1,
    parameter logic [7:0] INIT_CODE  = 8'h11
) (
    input  logic               clk,
    input  logic               rst_n,
    spi_frame_bridge_if.slave  bus
);
    localparam int             W         = 8 * DATA_BYTES;
    localparam int             BCW       = $clog2(DATA_BYTES + 2);
    localparam logic [BCW-1:0] LAST_BYTE = BCW'(DATA_BYTES);
    localparam logic [BCW-1:0] SAT_BYTE  = BCW'(DATA_BYTES + 1);
    localparam int             FIRST     = LSB_FIRST ? 0 : 7;

    logic [1:0] sck_s, ss_s, mosi_s;
    logic       sck_d, ss_d;
    logic       sck_rise, sck_fall, ss_rise, ss_fall;

    frame_state_t   state;
    logic [2:0]     bit_cnt, tx_idx;
    logic [BCW-1:0] byte_cnt;
    logic [7:0]     shift_in, byte_next, opcode, tx_byte, reply_byte, status;
    logic [W-1:0]   payload, reply_word;
    logic           rd_hit, miso;
    logic [7:0]     cmd;
    logic           cmd_valid, data_out_valid, link_up, frame_err, drop_flag;
    logic [W-1:0]   data_out;

    logic [W-1:0] fifo_head;
    logic         fifo_full, fifo_empty, fifo_pop, fifo_flush, exec_live;

    // Two-flop synchronisers plus one delay stage for edge detection. SS
    // resets low so a reset taken mid-frame cannot fake an SS fall.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sck_s  <= '0;
            ss_s   <= '0;
            mosi_s <= '0;
            sck_d  <= 1'b0;
            ss_d   <= 1'b0;
        end else begin
            sck_s  <= {sck_s[0], bus.spi_sck};
            ss_s   <= {ss_s[0], bus.spi_ss};
            mosi_s <= {mosi_s[0], bus.spi_mosi};
            sck_d  <= sck_s[1];
            ss_d   <= ss_s[1];
        end
    end

    assign sck_rise = sck_s[1] & ~sck_d;
    assign sck_fall = ~sck_s[1] & sck_d;
    assign ss_rise  = ss_s[1] & ~ss_d;
    assign ss_fall  = ~ss_s[1] & ss_d;

    assign byte_next = LSB_FIRST ? {mosi_s[1], shift_in[7:1]} : {shift_in[6:0], mosi_s[1]};
    assign tx_idx    = LSB_FIRST ? bit_cnt : 3'd7 - bit_cnt;
    assign status    = status_byte(link_up, drop_flag, fifo_full, !fifo_empty);

    // Reply byte for the byte about to start; past the frame it is filler.
    always_comb begin
        reply_byte = FILLER;
        for (int k = 1; k <= DATA_BYTES; k++)
            if (byte_cnt == BCW'(k)) reply_byte = reply_word[8*(k-1) +: 8];
    end

    assign exec_live  = (state == S_EXEC) && link_up;
    assign fifo_pop   = exec_live && (opcode == OP_READ_DATA) && rd_hit;
    assign fifo_flush = exec_live && (opcode == OP_CLEAR);

    // Frame FSM with the bit/byte engine and all registered outputs.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state          <= S_IDLE;
            bit_cnt        <= '0;
            byte_cnt       <= '0;
            shift_in       <= '0;
            opcode         <= '0;
            payload        <= '0;
            reply_word     <= '0;
            rd_hit         <= 1'b0;
            tx_byte        <= '0;
            miso           <= 1'b0;
            cmd            <= '0;
            cmd_valid      <= 1'b0;
            data_out       <= '0;
            data_out_valid <= 1'b0;
            link_up        <= 1'b0;
            frame_err      <= 1'b0;
        end else begin
            cmd_valid      <= 1'b0;
            data_out_valid <= 1'b0;
            frame_err      <= 1'b0;

            // Shift engine runs for the whole SS-low window, including
            // trailing bytes so MISO keeps sending filler.
            if (state != S_IDLE) begin
                if (sck_rise) begin
                    shift_in <= byte_next;
                    bit_cnt  <= bit_cnt + 3'd1;
                    if (bit_cnt == 3'd7) begin
                        if (byte_cnt != SAT_BYTE) byte_cnt <= byte_cnt + BCW'(1);
                        if (byte_cnt == '0) begin
                            // Reply source is fixed here; the head is only
                            // peeked now and popped at EXEC.
                            opcode <= byte_next;
                            rd_hit <= (byte_next == OP_READ_DATA) && link_up && !fifo_empty;
                            reply_word <= ((byte_next == OP_READ_DATA) && link_up && !fifo_empty)
                                          ? fifo_head : {DATA_BYTES{FILLER}};
                        end
                        for (int k = 0; k < DATA_BYTES; k++)
                            if (byte_cnt == BCW'(k + 1)) payload[8*k +: 8] <= byte_next;
                    end
                end
                if (sck_fall) begin
                    if (bit_cnt == 3'd0) begin
                        tx_byte <= reply_byte;
                        miso    <= reply_byte[FIRST];
                    end else begin
                        miso    <= tx_byte[tx_idx];
                    end
                end
            end

            case (state)
                S_IDLE: begin
                    if (ss_fall) begin
                        state    <= S_OPCODE;
                        bit_cnt  <= '0;
                        byte_cnt <= '0;
                        tx_byte  <= status;
                        miso     <= status[FIRST];
                    end
                end
                S_OPCODE: begin
                    if (ss_rise) begin
                        state     <= S_IDLE;
                        frame_err <= 1'b1;
                    end else if (sck_rise && bit_cnt == 3'd7) begin
                        state <= S_PAYLOAD;
                    end
                end
                S_PAYLOAD: begin
                    if (ss_rise) begin
                        state     <= S_IDLE;
                        frame_err <= 1'b1;
                    end else if (sck_rise && bit_cnt == 3'd7 && byte_cnt == LAST_BYTE) begin
                        state <= S_EXEC;
                    end
                end
                S_EXEC: begin
                    state <= S_TRAIL;
                    if (opcode == INIT_CODE) begin
                        link_up <= 1'b1;
                    end else if (link_up) begin
                        case (opcode)
                            OP_WRITE_CMD: begin
                                cmd       <= payload[7:0];
                                cmd_valid <= 1'b1;
                            end
                            OP_WRITE_DATA: begin
                                data_out       <= payload;
                                data_out_valid <= 1'b1;
                            end
                            default: ;
                        endcase
                    end
                end
                S_TRAIL: begin
                    // Level check so an SS rise that raced EXEC is not lost.
                    if (ss_s[1]) state <= S_IDLE;
                end
                default: state <= S_IDLE;
            endcase
        end
    end

    // Sticky overflow flag; CLEAR wins over a coincident dropped push.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)                                   drop_flag <= 1'b0;
        else if (fifo_flush)                          drop_flag <= 1'b0;
        else if (bus.spi_data_in_valid && fifo_full)  drop_flag <= 1'b1;
    end

    word_fifo #(.W(W), .DEPTH(TX_DEPTH)) u_fifo (
        .clk       (clk),
        .rst_n     (rst_n),
        .push      (bus.spi_data_in_valid && !fifo_full),
        .push_data (bus.spi_data_in),
        .pop       (fifo_pop),
        .flush     (fifo_flush),
        .head      (fifo_head),
        .full      (fifo_full),
        .empty     (fifo_empty)
    );

    assign bus.spi_miso           = miso;
    assign bus.spi_cmd            = cmd;
    assign bus.spi_cmd_valid      = cmd_valid;
    assign bus.spi_data_out       = data_out;
    assign bus.spi_data_out_valid = data_out_valid;
    assign bus.spi_data_in_free   = !fifo_full;
    assign bus.link_up            = link_up;
    assign bus.frame_err          = frame_err;
endmodule

// File: tb/tb_spi_frame_bridge.sv
// Directed bench: an LSB-first bridge (dut0) and an MSB-first bridge (dut1)
// share SCK/MOSI; each has its own SS so only one listens at a time.
module tb_spi_frame_bridge;
    localparam int HALF = 6;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    logic sck = 1'b0, mosi = 1'b0, ss0 = 1'b1, ss1 = 1'b1;
    logic [31:0] din0 = '0, din1 = '0;
    logic dv0 = 1'b0, dv1 = 1'b0;

    int n_chk = 0;
    int n_pass = 0;
    int dov0 = 0, dov1 = 0, cv0 = 0, fe0 = 0, fe1 = 0;

    spi_frame_bridge_if #(.W(32)) bus0 ();
    spi_frame_bridge_if #(.W(32)) bus1 ();

    assign bus0.spi_sck = sck;
    assign bus0.spi_ss = ss0;
    assign bus0.spi_mosi = mosi;
    assign bus0.spi_data_in = din0;
    assign bus0.spi_data_in_valid = dv0;
    assign bus1.spi_sck = sck;
    assign bus1.spi_ss = ss1;
    assign bus1.spi_mosi = mosi;
    assign bus1.spi_data_in = din1;
    assign bus1.spi_data_in_valid = dv1;

    spi_frame_bridge #(.DATA_BYTES(4), .TX_DEPTH(4), .LSB_FIRST(1'b1), .INIT_CODE(8'h11)) dut0 (
        .clk(clk), .rst_n(rst_n), .bus(bus0));
    spi_frame_bridge #(.DATA_BYTES(4), .TX_DEPTH(4), .LSB_FIRST(1'b0), .INIT_CODE(8'h11)) dut1 (
        .clk(clk), .rst_n(rst_n), .bus(bus1));

    always #5 clk = ~clk;

    // Pulse counters for the one-cycle strobes.
    always @(posedge clk) begin
        if (bus0.spi_data_out_valid) dov0++;
        if (bus1.spi_data_out_valid) dov1++;
        if (bus0.spi_cmd_valid) cv0++;
        if (bus0.frame_err) fe0++;
        if (bus1.frame_err) fe1++;
    end

    initial begin
        #2ms;
        $display("FAIL timeout got running want finished");
        $fatal(1, "timeout");
    end

    task automatic spi_xfer(input bit sel, input bit msb, input int nbytes,
                            input logic [63:0] txv, output logic [63:0] rxv);
        logic [7:0] tbyte, rb;
        int bi;
        rxv = '0;
        if (sel) ss1 = 1'b0; else ss0 = 1'b0;
        repeat (6) @(negedge clk);
        for (int k = 0; k < nbytes; k++) begin
            tbyte = txv[8*k +: 8];
            rb = '0;
            for (int i = 0; i < 8; i++) begin
                bi = msb ? 7 - i : i;
                mosi = tbyte[bi];
                repeat (HALF) @(negedge clk);
                rb[bi] = sel ? bus1.spi_miso : bus0.spi_miso;
                sck = 1'b1;
                repeat (HALF) @(negedge clk);
                sck = 1'b0;
            end
            rxv[8*k +: 8] = rb;
        end
        repeat (HALF) @(negedge clk);
        ss0 = 1'b1;
        ss1 = 1'b1;
        repeat (10) @(negedge clk);
    endtask

    task automatic push(input bit sel, input logic [31:0] w);
        @(negedge clk);
        if (sel) begin din1 = w; dv1 = 1'b1; end else begin din0 = w; dv0 = 1'b1; end
        @(negedge clk);
        dv0 = 1'b0;
        dv1 = 1'b0;
        repeat (2) @(negedge clk);
    endtask

    task automatic test_reset;
        repeat (4) @(negedge clk);
        rst_n = 1'b1;
        repeat (2) @(negedge clk);
        n_chk++; if (bus0.link_up !== 1'b0) $display("FAIL reset_link got %0h want 0", bus0.link_up); else n_pass++;
        n_chk++; if (bus0.spi_data_in_free !== 1'b1) $display("FAIL reset_free got %0h want 1", bus0.spi_data_in_free); else n_pass++;
        n_chk++; if (bus0.spi_cmd !== 8'h00) $display("FAIL reset_cmd got %0h want 0", bus0.spi_cmd); else n_pass++;
        n_chk++; if (bus0.spi_data_out !== 32'h0) $display("FAIL reset_data got %0h want 0", bus0.spi_data_out); else n_pass++;
        n_chk++; if (bus0.spi_miso !== 1'b0) $display("FAIL reset_miso got %0h want 0", bus0.spi_miso); else n_pass++;
        n_chk++; if ({bus0.spi_cmd_valid, bus0.spi_data_out_valid, bus0.frame_err} !== 3'b000)
            $display("FAIL reset_pulses got %0b want 000", {bus0.spi_cmd_valid, bus0.spi_data_out_valid, bus0.frame_err}); else n_pass++;
    endtask

    task automatic test_pre_init;
        logic [63:0] rx;
        int d0;
        d0 = dov0;
        spi_xfer(1'b0, 1'b0, 5, 64'hDEADBEEF04, rx);
        n_chk++; if (rx[39:0] !== 40'h4242424240) $display("FAIL preinit_reply got %0h want 4242424240", rx[39:0]); else n_pass++;
        n_chk++; if (dov0 - d0 !== 0) $display("FAIL preinit_no_pulse got %0d want 0", dov0 - d0); else n_pass++;
        spi_xfer(1'b0, 1'b0, 5, 64'h0000000011, rx);
        n_chk++; if (bus0.link_up !== 1'b1) $display("FAIL init_link got %0h want 1", bus0.link_up); else n_pass++;
        spi_xfer(1'b0, 1'b0, 5, 64'h0000000000, rx);
        n_chk++; if (rx[7:0] !== 8'h60) $display("FAIL init_status got %0h want 60", rx[7:0]); else n_pass++;
    endtask

    task automatic test_write;
        logic [63:0] rx;
        int d0, c0;
        d0 = dov0;
        c0 = cv0;
        spi_xfer(1'b0, 1'b0, 5, 64'hDEADBEEF04, rx);
        n_chk++; if (bus0.spi_data_out !== 32'hDEADBEEF) $display("FAIL write_data got %0h want deadbeef", bus0.spi_data_out); else n_pass++;
        n_chk++; if (dov0 - d0 !== 1) $display("FAIL write_data_pulses got %0d want 1", dov0 - d0); else n_pass++;
        spi_xfer(1'b0, 1'b0, 5, 64'h000000002A03, rx);
        n_chk++; if (bus0.spi_cmd !== 8'h2A) $display("FAIL write_cmd got %0h want 2a", bus0.spi_cmd); else n_pass++;
        n_chk++; if (cv0 - c0 !== 1) $display("FAIL write_cmd_pulses got %0d want 1", cv0 - c0); else n_pass++;
    endtask

    task automatic test_read;
        logic [63:0] rx;
        push(1'b0, 32'h01020304);
        spi_xfer(1'b0, 1'b0, 5, 64'h02, rx);
        n_chk++; if (rx[39:0] !== 40'h0102030461) $display("FAIL read_word got %0h want 0102030461", rx[39:0]); else n_pass++;
        spi_xfer(1'b0, 1'b0, 5, 64'h02, rx);
        n_chk++; if (rx[39:0] !== 40'h4242424260) $display("FAIL read_empty got %0h want 4242424260", rx[39:0]); else n_pass++;
    endtask

    task automatic test_overflow;
        logic [63:0] rx;
        for (int i = 0; i < 5; i++) push(1'b0, 32'hA0 + i);
        n_chk++; if (bus0.spi_data_in_free !== 1'b0) $display("FAIL ovf_free got %0h want 0", bus0.spi_data_in_free); else n_pass++;
        spi_xfer(1'b0, 1'b0, 5, 64'h00, rx);
        n_chk++; if (rx[7:0] !== 8'h67) $display("FAIL ovf_status got %0h want 67", rx[7:0]); else n_pass++;
        spi_xfer(1'b0, 1'b0, 5, 64'h05, rx);
        n_chk++; if (bus0.spi_data_in_free !== 1'b1) $display("FAIL clear_free got %0h want 1", bus0.spi_data_in_free); else n_pass++;
        spi_xfer(1'b0, 1'b0, 5, 64'h00, rx);
        n_chk++; if (rx[7:0] !== 8'h60) $display("FAIL clear_status got %0h want 60", rx[7:0]); else n_pass++;
    endtask

    task automatic test_abort;
        logic [63:0] rx;
        int f0;
        push(1'b0, 32'h55667788);
        f0 = fe0;
        spi_xfer(1'b0, 1'b0, 2, 64'h02, rx);
        n_chk++; if (rx[15:0] !== 16'h8861) $display("FAIL abort_partial got %0h want 8861", rx[15:0]); else n_pass++;
        n_chk++; if (fe0 - f0 !== 1) $display("FAIL abort_err_pulses got %0d want 1", fe0 - f0); else n_pass++;
        spi_xfer(1'b0, 1'b0, 5, 64'h02, rx);
        n_chk++; if (rx[39:0] !== 40'h5566778861) $display("FAIL abort_reread got %0h want 5566778861", rx[39:0]); else n_pass++;
        n_chk++; if (fe0 - f0 !== 1) $display("FAIL full_frame_err got %0d want 1", fe0 - f0); else n_pass++;
    endtask

    task automatic test_msb_first;
        logic [63:0] rx;
        int d1;
        spi_xfer(1'b1, 1'b1, 5, 64'h11, rx);
        n_chk++; if (bus1.link_up !== 1'b1) $display("FAIL msb_link got %0h want 1", bus1.link_up); else n_pass++;
        d1 = dov1;
        spi_xfer(1'b1, 1'b1, 5, 64'hDEADBEEF04, rx);
        n_chk++; if (bus1.spi_data_out !== 32'hDEADBEEF) $display("FAIL msb_data got %0h want deadbeef", bus1.spi_data_out); else n_pass++;
        n_chk++; if (dov1 - d1 !== 1) $display("FAIL msb_data_pulses got %0d want 1", dov1 - d1); else n_pass++;
        push(1'b1, 32'hCAFEF00D);
        spi_xfer(1'b1, 1'b1, 5, 64'h02, rx);
        n_chk++; if (rx[39:0] !== 40'hCAFEF00D61) $display("FAIL msb_read got %0h want cafef00d61", rx[39:0]); else n_pass++;
    endtask

    task automatic test_reset_mid;
        logic [63:0] rx;
        logic [15:0] pat;
        int f1, d1;
        f1 = fe1;
        d1 = dov1;
        pat = 16'h0304;
        ss1 = 1'b0;
        repeat (6) @(negedge clk);
        for (int i = 0; i < 16; i++) begin
            mosi = pat[15 - i];
            if (i == 10) begin
                rst_n = 1'b0;
                repeat (2) @(negedge clk);
                rst_n = 1'b1;
            end
            repeat (HALF) @(negedge clk);
            sck = 1'b1;
            repeat (HALF) @(negedge clk);
            sck = 1'b0;
        end
        repeat (HALF) @(negedge clk);
        ss1 = 1'b1;
        repeat (10) @(negedge clk);
        n_chk++; if (bus1.link_up !== 1'b0) $display("FAIL rstmid_link got %0h want 0", bus1.link_up); else n_pass++;
        n_chk++; if (bus1.spi_data_out !== 32'h0) $display("FAIL rstmid_data got %0h want 0", bus1.spi_data_out); else n_pass++;
        n_chk++; if (bus1.spi_data_in_free !== 1'b1) $display("FAIL rstmid_free got %0h want 1", bus1.spi_data_in_free); else n_pass++;
        n_chk++; if (bus1.spi_miso !== 1'b0) $display("FAIL rstmid_miso got %0h want 0", bus1.spi_miso); else n_pass++;
        n_chk++; if ((fe1 - f1) + (dov1 - d1) !== 0) $display("FAIL rstmid_pulses got %0d want 0", (fe1 - f1) + (dov1 - d1)); else n_pass++;
        spi_xfer(1'b1, 1'b1, 5, 64'h00, rx);
        n_chk++; if (rx[7:0] !== 8'h40) $display("FAIL rstmid_status got %0h want 40", rx[7:0]); else n_pass++;
        n_chk++; if (bus0.link_up !== 1'b0) $display("FAIL rstmid_link0 got %0h want 0", bus0.link_up); else n_pass++;
    endtask

    initial begin
        test_reset;
        test_pre_init;
        test_write;
        test_read;
        test_overflow;
        test_abort;
        test_msb_first;
        test_reset_mid;
        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end
endmodule

// File: doc/spi_frame_bridge.md
# spi_frame_bridge

Parametrised fabric SPI slave (mode 0, no hard IP) between the host SPI link and the image-processing core. Frames the byte stream into fixed-length packets of one opcode byte plus `DATA_BYTES` payload bytes. Emits command and data words to the core, and returns status plus queued result words from a `TX_DEPTH`-deep FIFO. Supersedes the single-byte, 2-reply-byte hard-SPI interface with configurable word width, bit order and a buffered return path.

## Interface
- `DATA_BYTES`, 4: payload bytes per frame; word width W = 8*DATA_BYTES (1..8).
- `TX_DEPTH`, 4: result FIFO depth, power of 2 (2..16).
- `LSB_FIRST`, 1: 1 = LSB-first bit order on the wire; 0 = MSB-first.
- `INIT_CODE`, 8'h11: opcode that brings the link up.

Ports:
- `clk` in 1: system clock.
- `rst_n` in 1: reset; one clock, asynchronous, active-low.
- `spi_sck`, `spi_ss`, `spi_mosi` in 1: async SPI pins; `spi_ss` active-low.
- `spi_miso` out 1: serial reply.
- `spi_cmd` out 8: command byte; `spi_cmd_valid` out 1: 1-cycle pulse.
- `spi_data_out` out W: data word; `spi_data_out_valid` out 1: 1-cycle pulse.
- `spi_data_in` in W: result word; `spi_data_in_valid` in 1: push request.
- `spi_data_in_free` out 1: FIFO not full.
- `link_up` out 1: INIT received.
- `frame_err` out 1: 1-cycle pulse on aborted frame.

## Operation
- Reset values: all outputs 0 except `spi_data_in_free` = 1. FIFO is empty, sticky drop flag is 0, link is down.
- Input path: SCK, SS and MOSI each pass through a 2-flop synchroniser, followed by edge detect. MOSI is sampled on the synced SCK rise. MISO updates on the synced SCK fall; bit 0 of byte 0 is presented on the synced SS fall.
- Bit counter 0..7; byte counter saturates at DATA_BYTES+1. Byte k (k ≥ 1) is payload byte k-1, little-endian within W.
- Reply byte 0 is status:
  - bit6 = 1 (marker)
  - bit5 = link_up
  - bit2 = sticky drop flag
  - bit1 = FIFO full
  - bit0 = FIFO not empty
  - all other bits 0
- Reply for bytes 1..DATA_BYTES is decided at byte-0 completion. If the opcode is READ_DATA, link_up = 1 and the FIFO is non-empty, the FIFO head word is shifted out (peek only). Otherwise the filler 8'h42 is repeated.
- Opcodes are executed at completion of byte DATA_BYTES. Every opcode other than INIT_CODE is ignored while link_up = 0.
  - INIT_CODE: link_up <= 1.
  - 0x00 NOP: no effect.
  - 0x02 READ_DATA: pops the word that was sent.
  - 0x03 WRITE_CMD: `spi_cmd` <= payload byte 0; pulses `spi_cmd_valid`.
  - 0x04 WRITE_DATA: `spi_data_out` <= payload word; pulses `spi_data_out_valid`.
  - 0x05 CLEAR: flushes the FIFO and clears the drop flag.
  - Any other opcode: no effect.
- SS rising before byte DATA_BYTES completes: frame discarded, no pop, `frame_err` pulses. Bytes beyond the frame length are ignored; MISO sends 8'h42.
- FIFO rules:
  - A push is accepted when `spi_data_in_valid` and `spi_data_in_free` are both high.
  - A push while full is dropped and sets the drop flag.
  - Push and pop in the same cycle leave the count unchanged.
  - CLEAR coinciding with a push: CLEAR wins and the FIFO ends empty.
- Frame FSM:
  - IDLE: on SS fall, go to OPCODE.
  - OPCODE: after 8 bits, go to PAYLOAD.
  - PAYLOAD: after DATA_BYTES bytes, go to EXEC.
  - EXEC: one cycle, then TRAIL.
  - TRAIL: on SS rise, go to IDLE.
  - SS rise from OPCODE or PAYLOAD: go to IDLE and pulse `frame_err`.
- Asynchronous reset mid-frame returns to IDLE and drops link_up. The host must re-send INIT.

## Timing
- Requires f_clk ≥ 8·f_sck, with SS held low for at least 4 clk before the first SCK rise.
- Output valid pulses occur 4 clk after the final SCK rise at the pin (2 sync stages + edge detect + EXEC). Jitter is ±1 clk due to async sampling.
- The pop takes effect in the EXEC cycle. `spi_data_in_free` updates the cycle after any push or pop.
- The status byte reflects FIFO state sampled at the synced SS fall.

## Structure
- Package `spi_frame_pkg` holds:
  - opcode constants
  - status bit indices
  - filler 8'h42
  - FSM state encoding
- Sub-module `word_fifo`: synchronous W×TX_DEPTH FIFO with async active-low reset, peek/pop/push/flush ports, full/empty flags, and wrap-around pointers with an extra MSB.
- Synchronisers stay inline.

## Test plan
- Before INIT, a WRITE_DATA frame: no `spi_data_out_valid` pulse; status byte reads 8'h40. Then a 0x11 frame: `link_up` = 1 and the next status byte reads 8'h60.
- DATA_BYTES=4, frame 04 EF BE AD DE: `spi_data_out` = 32'hDEADBEEF, one pulse. Frame 03 2A: `spi_cmd` = 8'h2A.
- Push 32'h01020304, then a READ_DATA frame: MISO returns 61 04 03 02 01 and the FIFO becomes empty. READ_DATA on an empty FIFO returns 60 42 42 42 42.
- Push 5 words with TX_DEPTH=4: 5th is dropped, status reads 8'h67. CLEAR: status reads 8'h60.
- Raise SS after 2 bytes of READ_DATA: `frame_err` pulses, no pop; the next READ_DATA returns the same word.
- LSB_FIRST=0 build, plus reset asserted mid-frame: MSB-first framing is correct, and after reset all outputs are at reset values and `link_up` = 0.
